// File: rtl/class_result_tx_pkg.sv
// Shared definitions for the classification result transmitter.
// Network sizing mirrors network_params.h (NUM_CLASSES, FFN_OUT_BITWIDTH,
// CLASS_IDX_BITWIDTH) so RTL defaults track the network configuration.
package class_result_tx_pkg;

    // Network sizing, kept in lockstep with network_params.h
    localparam int unsigned NET_NUM_CLASSES        = 2;
    localparam int unsigned NET_FFN_OUT_BITWIDTH   = 15;
    localparam int unsigned NET_CLASS_IDX_BITWIDTH = 0;

    // Width of the dropped-edge counter when the overrun option is built in
    localparam int unsigned OVERRUN_W = 8;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        SEND = 2'd2
    } state_t;

endpackage

// File: rtl/class_result_tx_argmax_step.sv
// argmax_step: one signed compare-and-select step of the argmax scan.
// Ports:
//   best, best_idx   - current winner score / index
//   cand, cand_idx   - candidate score / index
//   new_best, new_idx - winner after this step (combinational)
// A candidate only replaces the winner when strictly greater, so ties keep
// the earlier (lower) index.
module argmax_step #(
    parameter int unsigned SCORE_W = 16,
    parameter int unsigned IDX_W   = 1
) (
    input  logic signed [SCORE_W-1:0] best,
    input  logic        [IDX_W-1:0]   best_idx,
    input  logic signed [SCORE_W-1:0] cand,
    input  logic        [IDX_W-1:0]   cand_idx,
    output logic signed [SCORE_W-1:0] new_best,
    output logic        [IDX_W-1:0]   new_idx
);

    logic take_cand;

    assign take_cand = (cand > best);
    assign new_best  = take_cand ? cand     : best;
    assign new_idx   = take_cand ? cand_idx : best_idx;

endmodule

// File: rtl/class_result_tx.sv
// class_result_tx: captures the network output scores on a rising edge of
// product_rdy, scans them one class per cycle for the signed argmax and
// offers the winning class/score on a valid/ready interface.
// Ports:
//   clock, reset     - single clock, synchronous active-high reset
//   product_rdy      - completion level from the matrix-multiply controller
//   scores_in        - NUM_CLASSES packed signed scores, class i at [i*SCORE_W +: SCORE_W]
//   result_valid     - classification offered (registered)
//   result_ready     - downstream acceptance
//   result_class     - argmax index, zero outside SEND
//   result_score     - winning score, zero outside SEND
//   busy             - high in every state except IDLE
//   overrun_count    - saturating count of dropped capture edges
//                      (present only with CLASS_RESULT_OVERRUN_CNT_EN defined)
module class_result_tx
    import class_result_tx_pkg::*;
#(
    parameter int unsigned NUM_CLASSES = NET_NUM_CLASSES,
    parameter int unsigned SCORE_W     = NET_FFN_OUT_BITWIDTH + 1,
    parameter int unsigned CLASS_W     = NET_CLASS_IDX_BITWIDTH + 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           product_rdy,
    input  logic [NUM_CLASSES*SCORE_W-1:0] scores_in,
    output logic                           result_valid,
    input  logic                           result_ready,
    output logic [CLASS_W-1:0]             result_class,
    output logic [SCORE_W-1:0]             result_score,
    output logic                           busy
`ifdef CLASS_RESULT_OVERRUN_CNT_EN
    ,
    output logic [OVERRUN_W-1:0]           overrun_count
`endif
);

    state_t                    state_q;
    logic                      prev_rdy_q;
    logic signed [SCORE_W-1:0] scores_q [NUM_CLASSES];
    logic signed [SCORE_W-1:0] best_q;
    logic        [CLASS_W-1:0] best_idx_q;
    logic        [CLASS_W-1:0] idx_q;

    logic                      capture_edge;
    logic                      last_scan;
    logic signed [SCORE_W-1:0] step_best;
    logic        [CLASS_W-1:0] step_idx;

    // Rising edge of the completion level; prev register resets high so a
    // level held through reset is not mistaken for a new result.
    assign capture_edge = product_rdy & ~prev_rdy_q;
    assign last_scan    = (idx_q == CLASS_W'(NUM_CLASSES - 1));

    // Compare the class selected by idx_q against the running winner
    argmax_step #(
        .SCORE_W (SCORE_W),
        .IDX_W   (CLASS_W)
    ) u_step (
        .best     (best_q),
        .best_idx (best_idx_q),
        .cand     (scores_q[idx_q]),
        .cand_idx (idx_q),
        .new_best (step_best),
        .new_idx  (step_idx)
    );

    // Controller FSM with registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            prev_rdy_q   <= 1'b1;
            best_q       <= '0;
            best_idx_q   <= '0;
            idx_q        <= '0;
            result_valid <= 1'b0;
            result_class <= '0;
            result_score <= '0;
            busy         <= 1'b0;
            for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
                scores_q[i] <= '0;
            end
        end else begin
            prev_rdy_q <= product_rdy;
            case (state_q)
                IDLE: begin
                    if (capture_edge) begin
                        for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
                            scores_q[i] <= scores_in[i*SCORE_W +: SCORE_W];
                        end
                        best_q     <= scores_in[SCORE_W-1:0];
                        best_idx_q <= '0;
                        idx_q      <= CLASS_W'(1);
                        busy       <= 1'b1;
                        if (NUM_CLASSES > 1) begin
                            state_q <= SCAN;
                        end else begin
                            // Single class: the winner is known immediately
                            state_q      <= SEND;
                            result_valid <= 1'b1;
                            result_class <= '0;
                            result_score <= scores_in[SCORE_W-1:0];
                        end
                    end
                end
                SCAN: begin
                    best_q     <= step_best;
                    best_idx_q <= step_idx;
                    idx_q      <= idx_q + CLASS_W'(1);
                    if (last_scan) begin
                        state_q      <= SEND;
                        result_valid <= 1'b1;
                        result_class <= step_idx;
                        result_score <= step_best;
                    end
                end
                SEND: begin
                    if (result_ready) begin
                        state_q      <= IDLE;
                        result_valid <= 1'b0;
                        result_class <= '0;
                        result_score <= '0;
                        busy         <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    result_valid <= 1'b0;
                    result_class <= '0;
                    result_score <= '0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

`ifdef CLASS_RESULT_OVERRUN_CNT_EN
    // Count edges that arrive while a result is still in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            overrun_count <= '0;
        end else if (capture_edge && (state_q != IDLE) &&
                     (overrun_count != {OVERRUN_W{1'b1}})) begin
            overrun_count <= overrun_count + OVERRUN_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_class_result_tx.sv
// Testbench for class_result_tx: a 2-class and a 4-class instance share
// clock, reset, product_rdy and result_ready. A transaction-level model
// (argmax by loop, latency by countdown) is compared every cycle, and
// directed sequences pin the model with hand-computed literal values.
module tb_class_result_tx;

    localparam int unsigned SW = 16;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset        = 1'b1;
    logic product_rdy  = 1'b0;
    logic result_ready = 1'b0;

    int s2 [2];
    int s4 [4];
    logic [2*SW-1:0] scores2;
    logic [4*SW-1:0] scores4;

    logic          v2, b2, v4, b4;
    logic [0:0]    c2;
    logic [1:0]    c4;
    logic [SW-1:0] sc2, sc4;
`ifdef CLASS_RESULT_OVERRUN_CNT_EN
    logic [7:0]    ovr2, ovr4;
`endif

    always_comb begin
        for (int i = 0; i < 2; i++) scores2[i*SW +: SW] = SW'(s2[i]);
        for (int i = 0; i < 4; i++) scores4[i*SW +: SW] = SW'(s4[i]);
    end

    class_result_tx #(.NUM_CLASSES(2), .SCORE_W(SW), .CLASS_W(1)) dut2 (
        .clock        (clock),
        .reset        (reset),
        .product_rdy  (product_rdy),
        .scores_in    (scores2),
        .result_valid (v2),
        .result_ready (result_ready),
        .result_class (c2),
        .result_score (sc2),
        .busy         (b2)
`ifdef CLASS_RESULT_OVERRUN_CNT_EN
        ,
        .overrun_count(ovr2)
`endif
    );

    class_result_tx #(.NUM_CLASSES(4), .SCORE_W(SW), .CLASS_W(2)) dut4 (
        .clock        (clock),
        .reset        (reset),
        .product_rdy  (product_rdy),
        .scores_in    (scores4),
        .result_valid (v4),
        .result_ready (result_ready),
        .result_class (c4),
        .result_score (sc4),
        .busy         (b4)
`ifdef CLASS_RESULT_OVERRUN_CNT_EN
        ,
        .overrun_count(ovr4)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  ncls  [2] = '{2, 4};
    int  m_act [2];
    int  m_rem [2];
    int  m_cls [2];
    int  m_scr [2];
    int  m_ovr [2];
    bit  m_prev  = 1'b1;
    bit  started = 1'b0;
    bit  m_edge;
    int  m_was;
    int  m_v;

    always @(posedge clock) begin
        m_edge = product_rdy && !m_prev;
        if (reset) begin
            m_prev  = 1'b1;
            started = 1'b1;
            for (int k = 0; k < 2; k++) begin
                m_act[k] = 0; m_rem[k] = 0; m_ovr[k] = 0;
            end
        end else begin
            m_prev = product_rdy;
            for (int k = 0; k < 2; k++) begin
                m_was = m_act[k];
                if (m_was != 0 && m_rem[k] == 0 && result_ready) m_act[k] = 0;
                else if (m_was != 0 && m_rem[k] > 0) m_rem[k]--;
                if (m_edge) begin
                    if (m_was != 0) begin
                        if (m_ovr[k] < 255) m_ovr[k]++;
                    end else begin
                        // argmax with lowest index on ties; valid after N cycles
                        m_act[k] = 1;
                        m_rem[k] = ncls[k] - 1;
                        m_cls[k] = 0;
                        m_scr[k] = (k == 0) ? s2[0] : s4[0];
                        for (int i = 1; i < ncls[k]; i++) begin
                            m_v = (k == 0) ? s2[i] : s4[i];
                            if (m_v > m_scr[k]) begin
                                m_scr[k] = m_v; m_cls[k] = i;
                            end
                        end
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clock) begin
        if (started) begin
            int ev;
            ev = (m_act[0] != 0 && m_rem[0] == 0) ? 1 : 0;
            chk("m2.valid", v2, ev);
            chk("m2.busy", b2, (m_act[0] != 0) ? 1 : 0);
            chk("m2.class", c2, ev != 0 ? m_cls[0] : 0);
            chk("m2.score", $signed(sc2), ev != 0 ? m_scr[0] : 0);
            ev = (m_act[1] != 0 && m_rem[1] == 0) ? 1 : 0;
            chk("m4.valid", v4, ev);
            chk("m4.busy", b4, (m_act[1] != 0) ? 1 : 0);
            chk("m4.class", c4, ev != 0 ? m_cls[1] : 0);
            chk("m4.score", $signed(sc4), ev != 0 ? m_scr[1] : 0);
`ifdef CLASS_RESULT_OVERRUN_CNT_EN
            chk("m2.overrun", ovr2, m_ovr[0]);
            chk("m4.overrun", ovr4, m_ovr[1]);
`endif
        end
    end

    // Rising product_rdy for one cycle (cycle T); returns at negedge of T+1
    task automatic pulse();
        @(negedge clock);
        product_rdy = 1'b1;
        @(negedge clock);
        product_rdy = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clock);
        chk("reset.valid", v2, 0);
        chk("reset.busy", b2, 0);
        chk("reset.score", $signed(sc2), 0);
        reset = 1'b0;
        repeat (6) @(negedge clock);

        // Basic 2-class and 4-class latency and values
        s2 = '{100, -5};
        s4 = '{3, 9, 9, -1};
        result_ready = 1'b1;
        pulse();
        chk("basic.t1.valid", v2, 0);
        @(negedge clock);
        chk("basic.t2.valid", v2, 1);
        chk("basic.t2.class", c2, 0);
        chk("basic.t2.score", $signed(sc2), 100);
        chk("n4.t2.valid", v4, 0);
        @(negedge clock);
        chk("basic.t3.valid", v2, 0);
        chk("n4.t3.valid", v4, 0);
        @(negedge clock);
        chk("n4.t4.valid", v4, 1);
        chk("n4.t4.class", c4, 1);
        chk("n4.t4.score", $signed(sc4), 9);
        @(negedge clock);
        chk("n4.t5.valid", v4, 0);

        // Signed compare
        s2 = '{-7, -3};
        pulse();
        @(negedge clock);
        chk("signed.class", c2, 1);
        chk("signed.score", $signed(sc2), -3);
        repeat (4) @(negedge clock);

        // Tie keeps lowest index
        s2 = '{42, 42};
        pulse();
        @(negedge clock);
        chk("tie.valid", v2, 1);
        chk("tie.class", c2, 0);
        chk("tie.score", $signed(sc2), 42);
        repeat (4) @(negedge clock);

        // Backpressure: output held, second edge dropped
        do_reset();
        s2 = '{11, -20};
        result_ready = 1'b0;
        pulse();
        @(negedge clock);
        for (int i = 0; i < 20; i++) begin
            chk("hold.valid", v2, 1);
            chk("hold.class", c2, 0);
            chk("hold.score", $signed(sc2), 11);
            if (i == 5) product_rdy = 1'b1;
            if (i == 6) product_rdy = 1'b0;
            @(negedge clock);
        end
`ifdef CLASS_RESULT_OVERRUN_CNT_EN
        chk("hold.overrun2", ovr2, 1);
        chk("hold.overrun4", ovr4, 1);
`endif
        result_ready = 1'b1;
        @(negedge clock);
        chk("release.valid", v2, 0);
        repeat (3) @(negedge clock);

        // product_rdy held high through reset: no capture
        product_rdy = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("hold_rst.valid", v2, 0);
            chk("hold_rst.busy", b2, 0);
        end
        product_rdy = 1'b0;
        @(negedge clock);

        // Reset in T+1 abandons the scan
        @(negedge clock);
        product_rdy = 1'b1;
        @(negedge clock);
        product_rdy = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int t = 2; t <= 10; t++) begin
            chk("abort.valid2", v2, 0);
            chk("abort.valid4", v4, 0);
            @(negedge clock);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            @(negedge clock);
            if ($urandom_range(0, 3) == 0) product_rdy = ~product_rdy;
            result_ready = ($urandom_range(0, 2) != 0);
            reset = ($urandom_range(0, 99) == 0);
            for (int j = 0; j < 2; j++)
                s2[j] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 6)) - 3
                                                    : int'($urandom_range(0, 65535)) - 32768;
            for (int j = 0; j < 4; j++)
                s4[j] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 6)) - 3
                                                    : int'($urandom_range(0, 65535)) - 32768;
        end
        reset = 1'b0;
        product_rdy = 1'b0;
        repeat (8) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/class_result_tx.md
CLASS_RESULT_TX -- requirements
Module: class_result_tx

Interface
REQ-001 The block SHALL have parameter NUM_CLASSES, default `NUM_CLASSES (2), the number of network output scores.
REQ-002 The block SHALL have parameter SCORE_W, default `FFN_OUT_BITWIDTH+1, the width of each score (two's-complement signed).
REQ-003 The block SHALL have parameter CLASS_W, default `CLASS_IDX_BITWIDTH+1 (1), the width of the class index; it must be at least ceil(log2(NUM_CLASSES)), minimum 1.
REQ-004 The block SHALL have port clock, input, 1, the single clock.
REQ-005 The block SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-006 The block SHALL have port product_rdy, input, 1, the completion flag from the matrix-multiply controller (level; it may stay high).
REQ-007 The block SHALL have port scores_in, input, NUM_CLASSES*SCORE_W; class i is in bits [i*SCORE_W +: SCORE_W].
REQ-008 The block SHALL have port result_valid, output, 1, meaning a classification is offered.
REQ-009 The block SHALL have port result_ready, input, 1, the downstream acceptance signal.
REQ-010 The block SHALL have port result_class, output, CLASS_W, the argmax index.
REQ-011 The block SHALL have port result_score, output, SCORE_W, the winning score.
REQ-012 The block SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, SCAN and SEND.
REQ-014 The block SHALL define a capture edge as product_rdy=1 in cycle T while the registered previous product_rdy is 0.
REQ-015 On a capture edge in IDLE, at the end of cycle T the block SHALL register all NUM_CLASSES scores, set best_idx=0, set best=score[0] and set idx=1.
- If NUM_CLASSES>1 the next state is SCAN; otherwise it is SEND.
REQ-016 In SCAN the block SHALL compare one class per cycle: if score[idx] > best (signed, strict), then best_idx=idx and best=score[idx].
- idx increments each cycle.
- After idx=NUM_CLASSES-1 the next state is SEND.
REQ-017 On ties the block SHALL keep the lowest index.
REQ-018 The block SHALL assert result_valid exactly from cycle T+NUM_CLASSES.
REQ-019 In SEND the block SHALL hold result_valid=1 and keep result_class and result_score stable until result_ready=1 is sampled.
- The state then returns to IDLE, and result_valid=0 in the next cycle.
REQ-020 result_valid SHALL NOT depend combinationally on result_ready.
- result_ready asserted outside SEND is ignored.
REQ-021 A capture edge in SCAN or SEND, including the handshake cycle, SHALL be dropped and SHALL NOT disturb the in-flight result.
REQ-022 The block SHALL NOT capture again while product_rdy is held high; a new edge requires product_rdy to be low for at least 1 cycle.
REQ-023 result_class and result_score SHALL be zero-filled outside SEND.

Reset
REQ-024 Reset SHALL force the state to IDLE, result_valid=0, result_class=0, result_score=0, busy=0, the score registers to 0 and idx=0.
REQ-025 Reset SHALL set the previous-product_rdy register to 1, so product_rdy held high through reset is not captured.
REQ-026 Reset asserted mid-SCAN or mid-SEND SHALL abandon the operation with no output pulse.

Configuration
REQ-027 When macro CLASS_RESULT_OVERRUN_CNT_EN is defined, the block SHALL add output overrun_count (8 bits).
- It increments on each edge dropped per REQ-021.
- It saturates at 255 and resets to 0.
REQ-028 Without CLASS_RESULT_OVERRUN_CNT_EN the port and counter SHALL be absent and dropped edges SHALL be silent.

Structure
REQ-029 NUM_CLASSES, FFN_OUT_BITWIDTH and the new CLASS_IDX_BITWIDTH SHALL reside in the shared network_params.h.
REQ-030 The signed compare-and-select step SHALL be a sub-module named argmax_step: combinational, inputs (best, best_idx, cand, cand_idx), outputs (new best, new index).

Verification
REQ-031 With NUM_CLASSES=2, scores {n0=100, n1=-5}, a product_rdy pulse at cycle 10 and result_ready=1: result_valid SHALL be high in cycle 12 only, with class=0 and score=100.
REQ-032 Scores {n0=-7, n1=-3} SHALL yield class=1, score=-3 (signed compare check).
REQ-033 Scores {n0=42, n1=42} SHALL yield class=0 (tie rule).
REQ-034 With result_ready=0 for 20 cycles: valid, class and score SHALL stay constant.
- A second product_rdy pulse during that time SHALL be dropped, and overrun_count=1 when the macro is defined.
REQ-035 product_rdy held high across reset deassertion SHALL cause no capture.
- Reset pulsed in cycle T+1 after an edge SHALL give result_valid=0 through T+10.
REQ-036 With NUM_CLASSES=4 and scores {3,9,9,-1}: valid SHALL assert at T+4 with class=1 and score=9.
